// File: rtl/hdc_ctrl_pkg.sv
// Shared definitions for the HDC training control path.
// Contents: sequencer state enum, default class-index width and class count,
//           and the class index type used by the class-select datapath.
package hdc_ctrl_pkg;

  localparam int CLASS_W             = 5;
  localparam int NUM_CLASSES_DEFAULT = 26;

  typedef logic [CLASS_W-1:0] class_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    BIN_REQ,
    BIN_WAIT,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/hdc_train_sequencer.sv
// One-shot HDC training mode controller.
// Accepts labelled samples over a valid/ready handshake and issues a one-cycle
// accumulate pulse with the target class for every in-range label. After the
// sample flagged last, it walks every class through the binarizer, one
// bin_start / bin_class_done handshake per class, then pulses done.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begins a run (IDLE only)
//   sample_valid/_label/_last, sample_ready   sample handshake
//   bin_class_done           binarizer finished current class
//   training_hdc_model       accumulate enable (registered, 1-cycle latency)
//   class_select_bits        class to accumulate into, 0 otherwise
//   binarizing_class_hvs     high during the binarization phase
//   binarized_class_counter  class currently being binarized
//   bin_start                launch binarization of the current class
//   busy, done               not-idle flag, end-of-run pulse
//   label_err                sticky out-of-range label flag for this run
//   samples_trained          saturating count of accumulated samples
module hdc_train_sequencer #(
  parameter int NUM_CLASSES = hdc_ctrl_pkg::NUM_CLASSES_DEFAULT,
  parameter int CLASS_W     = hdc_ctrl_pkg::CLASS_W,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sample_valid,
  input  logic [CLASS_W-1:0] sample_label,
  input  logic               sample_last,
  output logic               sample_ready,
  input  logic               bin_class_done,
  output logic               training_hdc_model,
  output logic [CLASS_W-1:0] class_select_bits,
  output logic               binarizing_class_hvs,
  output logic [CLASS_W-1:0] binarized_class_counter,
  output logic               bin_start,
  output logic               busy,
  output logic               done,
  output logic               label_err,
  output logic [CNT_W-1:0]   samples_trained
);

  import hdc_ctrl_pkg::*;

  localparam int unsigned        NUM_CLASSES_U = NUM_CLASSES;
  localparam logic [CLASS_W-1:0] LAST_CLASS    = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX       = '1;

  seq_state_t state;
  logic       accept;
  logic       label_ok;

  assign sample_ready = (state == TRAIN);
  assign busy         = (state != IDLE);
  assign accept       = sample_valid && sample_ready;
  // Widen before comparing so NUM_CLASSES == 2**CLASS_W still works.
  assign label_ok     = (32'(sample_label) < NUM_CLASSES_U);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      training_hdc_model      <= 1'b0;
      class_select_bits       <= '0;
      binarizing_class_hvs    <= 1'b0;
      binarized_class_counter <= '0;
      bin_start               <= 1'b0;
      done                    <= 1'b0;
      label_err               <= 1'b0;
      samples_trained         <= '0;
    end else begin
      training_hdc_model <= 1'b0;
      class_select_bits  <= '0;
      bin_start          <= 1'b0;
      done               <= 1'b0;

      // Accumulate path runs independently of the state transition so the
      // final sample's pulse lands in the first BIN_REQ cycle.
      if (accept) begin
        if (label_ok) begin
          training_hdc_model <= 1'b1;
          class_select_bits  <= sample_label;
          if (samples_trained != CNT_MAX)
            samples_trained <= samples_trained + 1'b1;
        end else begin
          label_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state           <= TRAIN;
            label_err       <= 1'b0;
            samples_trained <= '0;
          end
        end
        TRAIN: begin
          if (accept && sample_last) begin
            state                   <= BIN_REQ;
            binarizing_class_hvs    <= 1'b1;
            bin_start               <= 1'b1;
            binarized_class_counter <= '0;
          end
        end
        // bin_start is high in this state; a done seen here is ignored.
        BIN_REQ: state <= BIN_WAIT;
        BIN_WAIT: begin
          if (bin_class_done) begin
            if (binarized_class_counter == LAST_CLASS) begin
              state <= FINISH;
            end else begin
              state                   <= BIN_REQ;
              bin_start               <= 1'b1;
              binarized_class_counter <= binarized_class_counter + 1'b1;
            end
          end
        end
        FINISH: begin
          state                   <= IDLE;
          done                    <= 1'b1;
          binarizing_class_hvs    <= 1'b0;
          binarized_class_counter <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_train_sequencer.sv
// Scoreboard bench for hdc_train_sequencer (NUM_CLASSES=4, CLASS_W=5, CNT_W=16).
module tb_hdc_train_sequencer;

  localparam int NC   = 4;
  localparam int CW   = 5;
  localparam int CNTW = 16;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            sample_valid = 1'b0;
  logic [CW-1:0]   sample_label = '0;
  logic            sample_last = 1'b0;
  logic            done_resp = 1'b0;
  logic            done_stray = 1'b0;
  logic            bin_class_done;
  logic            sample_ready;
  logic            training_hdc_model;
  logic [CW-1:0]   class_select_bits;
  logic            binarizing_class_hvs;
  logic [CW-1:0]   binarized_class_counter;
  logic            bin_start;
  logic            busy;
  logic            done;
  logic            label_err;
  logic [CNTW-1:0] samples_trained;

  assign bin_class_done = done_resp | done_stray;

  hdc_train_sequencer #(
    .NUM_CLASSES(NC),
    .CLASS_W(CW),
    .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sample_valid(sample_valid),
    .sample_label(sample_label),
    .sample_last(sample_last),
    .sample_ready(sample_ready),
    .bin_class_done(bin_class_done),
    .training_hdc_model(training_hdc_model),
    .class_select_bits(class_select_bits),
    .binarizing_class_hvs(binarizing_class_hvs),
    .binarized_class_counter(binarized_class_counter),
    .bin_start(bin_start),
    .busy(busy),
    .done(done),
    .label_err(label_err),
    .samples_trained(samples_trained)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int err;
  } run_t;

  int   checks = 0;
  int   failures = 0;
  int   acc_q[$];
  int   bin_q[$];
  run_t done_q[$];
  int   done_seen = 0;
  bit   in_bin = 1'b0;

  // reference model state for the current run
  int   cur_cnt = 0;
  int   cur_err = 0;

  // binarizer responder controls
  int   resp_delay = 2;
  bit   resp_random = 1'b0;
  bit   resp_at_start = 1'b0;
  int   hold_counter = -1;
  int   cd = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (training_hdc_model) begin
        if (acc_q.size() == 0) fail_now("acc_unexpected");
        else check("acc_class", class_select_bits, acc_q.pop_front());
      end else begin
        check("csel_idle_zero", class_select_bits, 0);
      end
      if (bin_start) begin
        in_bin = 1'b1;
        check("hvs_at_bin_start", binarizing_class_hvs, 1);
        if (bin_q.size() == 0) fail_now("bin_start_unexpected");
        else check("bin_counter", binarized_class_counter, bin_q.pop_front());
      end
      if (done) begin
        run_t r;
        check("done_busy_low", busy, 0);
        check("done_hvs_low", binarizing_class_hvs, 0);
        check("done_counter_zero", binarized_class_counter, 0);
        if (done_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          r = done_q.pop_front();
          check("done_samples", samples_trained, r.cnt);
          check("done_label_err", label_err, r.err);
        end
        in_bin = 1'b0;
        done_seen++;
      end else if (in_bin) begin
        check("hvs_during_bin", binarizing_class_hvs, 1);
      end
    end
  end

  // Binarizer model: answers each bin_start after a delay.
  always @(negedge clk) begin
    if (rst) begin
      cd = 0;
      done_resp = 1'b0;
    end else begin
      done_resp = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) done_resp = 1'b1;
      end
      if (bin_start && int'(binarized_class_counter) != hold_counter) begin
        cd = resp_random ? int'($urandom_range(1, 4)) : resp_delay;
        if (resp_at_start) done_resp = 1'b1;
      end
    end
  end

  task automatic model_start();
    cur_cnt = 0;
    cur_err = 0;
  endtask

  task automatic model_sample(input int lbl, input bit last);
    run_t r;
    if (lbl < NC) begin
      acc_q.push_back(lbl);
      if (cur_cnt < CMAX) cur_cnt++;
    end else begin
      cur_err = 1;
    end
    if (last) begin
      for (int c = 0; c < NC; c++) bin_q.push_back(c);
      r.cnt = cur_cnt;
      r.err = cur_err;
      done_q.push_back(r);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    model_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int lbl, input bit last, input int gap);
    repeat (gap) @(negedge clk);
    sample_valid = 1'b1;
    sample_label = CW'(lbl);
    sample_last  = last;
    model_sample(lbl, last);
    @(negedge clk);
    sample_valid = 1'b0;
    sample_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    int k;
    n0 = done_seen;
    k = 0;
    while (done_seen == n0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("done_arrived", done_seen, n0 + 1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, sample_ready, 0);
    check({tag, "_train"}, training_hdc_model, 0);
    check({tag, "_csel"}, class_select_bits, 0);
    check({tag, "_hvs"}, binarizing_class_hvs, 0);
    check({tag, "_counter"}, binarized_class_counter, 0);
    check({tag, "_bin_start"}, bin_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_label_err"}, label_err, 0);
    check({tag, "_samples"}, samples_trained, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // labels 3,7,3 back to back, 4-class binarization with 2-cycle replies
    resp_delay = 2;
    do_start();
    send(3, 1'b0, 0);
    send(7, 1'b0, 0);
    send(3, 1'b1, 0);
    wait_done();
    check("run1_samples", samples_trained, 2);

    // out-of-range label: dropped, label_err sticky, counter unchanged
    do_start();
    send(1, 1'b0, 0);
    send(30, 1'b0, 1);
    check("label_err_set", label_err, 1);
    check("samples_after_bad", samples_trained, 1);
    send(2, 1'b1, 0);
    wait_done();
    check("label_err_held", label_err, 1);
    do_start();
    check("label_err_cleared", label_err, 0);
    check("samples_cleared", samples_trained, 0);

    // ignored events: start in TRAIN, stray done in TRAIN, start in BIN_WAIT,
    // done coincident with bin_start
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    check("train_busy", busy, 1);
    check("train_ready", sample_ready, 1);
    send(0, 1'b0, 0);
    resp_delay = 4;
    resp_at_start = 1'b1;
    send(3, 1'b1, 0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    resp_at_start = 1'b0;

    // randomized runs
    resp_random = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      do_start();
      for (int i = 0; i < n; i++) begin
        int lbl;
        lbl = ($urandom_range(0, 9) == 0) ? 30 + int'($urandom_range(0, 1))
                                          : int'($urandom_range(0, 7));
        send(lbl, i == n - 1, int'($urandom_range(0, 2)));
      end
      wait_done();
    end
    resp_random = 1'b0;
    resp_delay = 2;

    // asynchronous reset while waiting on class 2
    hold_counter = 2;
    do_start();
    send(2, 1'b0, 0);
    send(1, 1'b1, 0);
    begin
      int k;
      k = 0;
      while (!(bin_start && binarized_class_counter == 2) && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("reach_counter2", binarized_class_counter, 2);
    end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    acc_q.delete();
    bin_q.delete();
    done_q.delete();
    in_bin = 1'b0;
    hold_counter = -1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int n0;
      n0 = done_seen;
      repeat (5) @(negedge clk);
      check("no_done_after_reset", done_seen, n0);
    end
    do_start();
    send(0, 1'b0, 0);
    send(3, 1'b1, 0);
    wait_done();

    // saturation of the sample counter
    do_start();
    for (int i = 0; i < CMAX + 5; i++) send(i % NC, i == CMAX + 4, 0);
    wait_done();
    check("samples_saturated", samples_trained, CMAX);

    repeat (3) @(negedge clk);
    check("acc_q_empty", acc_q.size(), 0);
    check("bin_q_empty", bin_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
